// File: rtl/apr_evt_pkg.sv
// apr_evt_pkg -- shared definitions for the apr_evt event/interrupt block.
//   rd_sel_e : diagnostic read-select encoding for apr_evt.rd_data
//   *_DEF    : default values for the NCH / PIA_W / CNT_W parameters
package apr_evt_pkg;

  localparam int NCH_DEF   = 8;
  localparam int PIA_W_DEF = 3;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    RD_FLAGS = 2'd0,  // next-state flags
    RD_EN    = 2'd1,  // interrupt enables
    RD_EVENT = 2'd2,  // raw event inputs
    RD_FIRST = 2'd3   // zero-extended {first_valid, first_idx}
  } rd_sel_e;

endpackage

// File: rtl/apr_evt_chan.sv
// apr_evt_chan -- one event channel: a sticky event flag plus its interrupt
// enable bit.
// Ports:
//   clk, RESET            clock and synchronous active-high reset
//   sel_en/sel_dis        enable / disable strobes (sel_en wins)
//   sel_set/sel_clr       flag set / clear strobes (set and evt win)
//   mask                  this channel's bit of the command mask
//   evt                   level hardware condition for this channel
//   flag, en              registered flag and interrupt enable
//   flag_next             combinational next value of flag (before reset)
module apr_evt_chan
  import apr_evt_pkg::*;
(
  input  logic clk,
  input  logic RESET,
  input  logic sel_en,
  input  logic sel_dis,
  input  logic sel_set,
  input  logic sel_clr,
  input  logic mask,
  input  logic evt,
  output logic flag,
  output logic en,
  output logic flag_next
);

  logic en_next;

  always_comb begin
    flag_next = evt | (sel_set & mask) | (flag & ~(sel_clr & mask));
    en_next   = (sel_en & mask) | (en & ~(sel_dis & mask));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      flag <= 1'b0;
      en   <= 1'b0;
    end else begin
      flag <= flag_next;
      en   <= en_next;
    end
  end

endmodule

// File: rtl/apr_evt.sv
// apr_evt -- per-channel sticky event flags with interrupt enables, a
// priority-interrupt assignment (PIA) register, a saturating count of cycles
// in which any flag rose, and optional first-error capture.
// Optional feature: define APR_EVT_FIRST_ERR_EN to build first-error capture;
// without it first_valid/first_idx are tied to 0 and hold no storage.
// Ports:
//   clk, RESET                       clock, synchronous active-high reset
//   sel_en/sel_dis/sel_set/sel_clr   command strobes, masked by data[NCH]
//   evt[NCH]                         level hardware event per channel
//   pia_ld, pia_in[PIA_W]            PIA register load
//   cnt_clr                          zero the error counter
//   rd_sel[2]                        diagnostic read select (rd_sel_e)
//   flags, int_en                    registered flags / enables
//   irq, irq_pia                     interrupt request and its PIA level
//   any_err                          one-cycle pulse after a flag-rise cycle
//   err_cnt[CNT_W]                   saturating count of flag-rise cycles
//   first_valid, first_idx           first-error capture
//   rd_data[NCH]                     diagnostic read bus
module apr_evt
  import apr_evt_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int PIA_W = PIA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     sel_en,
  input  logic                     sel_dis,
  input  logic                     sel_set,
  input  logic                     sel_clr,
  input  logic [NCH-1:0]           data,
  input  logic [NCH-1:0]           evt,
  input  logic                     pia_ld,
  input  logic [PIA_W-1:0]         pia_in,
  input  logic                     cnt_clr,
  input  logic [1:0]               rd_sel,
  output logic [NCH-1:0]           flags,
  output logic [NCH-1:0]           int_en,
  output logic                     irq,
  output logic [PIA_W-1:0]         irq_pia,
  output logic                     any_err,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     first_valid,
  output logic [$clog2(NCH)-1:0]   first_idx,
  output logic [NCH-1:0]           rd_data
);

  localparam int IDX_W = $clog2(NCH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [NCH-1:0]   flags_nxt;
  logic [NCH-1:0]   flags_rd;
  logic [NCH-1:0]   rise;
  logic             set_cyc;
  logic [PIA_W-1:0] pia_p0;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    apr_evt_chan u_chan (
      .clk       (clk),
      .RESET     (RESET),
      .sel_en    (sel_en),
      .sel_dis   (sel_dis),
      .sel_set   (sel_set),
      .sel_clr   (sel_clr),
      .mask      (data[g]),
      .evt       (evt[g]),
      .flag      (flags[g]),
      .en        (int_en[g]),
      .flag_next (flags_nxt[g])
    );
  end

  // Reset overrides everything, so the visible next state and the rise
  // detection both see zeros while RESET is high.
  always_comb begin
    flags_rd = RESET ? '0 : flags_nxt;
    rise     = flags_rd & ~flags;
    set_cyc  = |rise;
  end

  // ---- stage p0: PIA, error pulse and counter registers ----
  always_ff @(posedge clk) begin
    if (RESET) begin
      pia_p0  <= '0;
      any_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (pia_ld)
        pia_p0 <= pia_in;
      any_err <= set_cyc;
      if (cnt_clr)
        err_cnt <= '0;
      else if (set_cyc)
        err_cnt <= sat_inc(err_cnt);
    end
  end

  // PIA level 0 means the interrupt is disabled.
  always_comb begin
    irq     = (|(flags & int_en)) & (|pia_p0);
    irq_pia = irq ? pia_p0 : '0;
  end

`ifdef APR_EVT_FIRST_ERR_EN
  logic [IDX_W-1:0] low_idx;

  // Descending scan so the lowest rising index is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (rise[i])
        low_idx = IDX_W'(i);
  end

  // A captured flag can only fall through sel_clr, so a zero next-state on
  // the captured channel releases the capture; re-arming waits one cycle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      first_valid <= 1'b0;
      first_idx   <= '0;
    end else if (first_valid) begin
      if (!flags_nxt[first_idx])
        first_valid <= 1'b0;
    end else if (set_cyc) begin
      first_valid <= 1'b1;
      first_idx   <= low_idx;
    end
  end
`else
  assign first_valid = 1'b0;
  assign first_idx   = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_sel_e'(rd_sel))
      RD_FLAGS: rd_data = flags_rd;
      RD_EN:    rd_data = int_en;
      RD_EVENT: rd_data = evt;
      RD_FIRST: rd_data = NCH'({first_valid, first_idx});
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_apr_evt.sv
// tb_apr_evt -- directed testbench for apr_evt (default parameters:
// NCH=8, PIA_W=3, CNT_W=4). First-error checks follow APR_EVT_FIRST_ERR_EN.
module tb_apr_evt;

  logic       clk = 1'b0;
  logic       RESET;
  logic       sel_en, sel_dis, sel_set, sel_clr;
  logic [7:0] data, evt;
  logic       pia_ld;
  logic [2:0] pia_in;
  logic       cnt_clr;
  logic [1:0] rd_sel;
  logic [7:0] flags, int_en, rd_data;
  logic       irq, any_err, first_valid;
  logic [2:0] irq_pia, first_idx;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

  apr_evt dut (
    .clk         (clk),
    .RESET       (RESET),
    .sel_en      (sel_en),
    .sel_dis     (sel_dis),
    .sel_set     (sel_set),
    .sel_clr     (sel_clr),
    .data        (data),
    .evt         (evt),
    .pia_ld      (pia_ld),
    .pia_in      (pia_in),
    .cnt_clr     (cnt_clr),
    .rd_sel      (rd_sel),
    .flags       (flags),
    .int_en      (int_en),
    .irq         (irq),
    .irq_pia     (irq_pia),
    .any_err     (any_err),
    .err_cnt     (err_cnt),
    .first_valid (first_valid),
    .first_idx   (first_idx),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    sel_en = 1'b0; sel_dis = 1'b0; sel_set = 1'b0; sel_clr = 1'b0;
    data = 8'h00; evt = 8'h00; pia_ld = 1'b0; pia_in = 3'd0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    idle();
    rd_sel = 2'd0;
    RESET  = 1'b1;
    tick();
    tick();
    RESET = 1'b0;

    // Reset state
    chk("rst_flags",   32'(flags), 0);
    chk("rst_int_en",  32'(int_en), 0);
    chk("rst_irq",     32'(irq), 0);
    chk("rst_any_err", 32'(any_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_fvalid",  32'(first_valid), 0);
    chk("rst_fidx",    32'(first_idx), 0);

    // Enable-then-event
    sel_en = 1'b1; data = 8'h04; pia_ld = 1'b1; pia_in = 3'd5;
    tick(); idle();
    chk("en_int_en", 32'(int_en), 'h04);
    chk("en_irq_noflag", 32'(irq), 0);
    rd_sel = 2'd1; #1;
    chk("rd_en", 32'(rd_data), 'h04);
    evt = 8'h5A; rd_sel = 2'd2; #1;
    chk("rd_event", 32'(rd_data), 'h5A);
    evt = 8'h04;
    tick(); idle();
    chk("ev_flags",   32'(flags), 'h04);
    chk("ev_irq",     32'(irq), 1);
    chk("ev_irq_pia", 32'(irq_pia), 5);
    chk("ev_any_err", 32'(any_err), 1);
    chk("ev_err_cnt", 32'(err_cnt), 1);
    tick();
    chk("ev_any_err_pulse", 32'(any_err), 0);
    chk("ev_err_cnt_hold",  32'(err_cnt), 1);
    chk("ev_flag_sticky",   32'(flags), 'h04);

    // PIA 0 disables the interrupt
    pia_ld = 1'b1; pia_in = 3'd0;
    tick(); idle();
    chk("pia0_irq",     32'(irq), 0);
    chk("pia0_irq_pia", 32'(irq_pia), 0);
    pia_ld = 1'b1; pia_in = 3'd3;
    tick(); idle();
    chk("pia3_irq",     32'(irq), 1);
    chk("pia3_irq_pia", 32'(irq_pia), 3);

    // sel_en beats sel_dis, then disable
    sel_en = 1'b1; sel_dis = 1'b1; data = 8'h02;
    tick(); idle();
    chk("en_wins", 32'(int_en), 'h06);
    sel_dis = 1'b1; data = 8'h06;
    tick(); idle();
    chk("dis_int_en", 32'(int_en), 'h00);
    chk("dis_irq",    32'(irq), 0);

    // Simultaneous set/clear
    sel_clr = 1'b1; data = 8'hFF;
    tick(); idle();
    chk("clr_all", 32'(flags), 'h00);
    sel_en = 1'b1; sel_set = 1'b1; data = 8'h01;
    tick(); idle();
    chk("set_flags",   32'(flags), 'h01);
    chk("set_irq",     32'(irq), 1);
    chk("set_err_cnt", 32'(err_cnt), 2);
    evt = 8'h01; sel_clr = 1'b1; data = 8'h01; rd_sel = 2'd0; #1;
    chk("rd_next_evt_wins", 32'(rd_data), 'h01);
    tick();
    chk("evt_beats_clr", 32'(flags), 'h01);
    chk("no_rise_cnt",   32'(err_cnt), 2);
    chk("no_rise_err",   32'(any_err), 0);
    evt = 8'h00; #1;
    chk("rd_next_clr", 32'(rd_data), 'h00);
    tick(); idle();
    chk("clr_flags", 32'(flags), 'h00);
    chk("clr_irq",   32'(irq), 0);

    // Counter: multi-channel rise counts once, saturation, cnt_clr priority
    do_reset();
    evt = 8'hFF;
    tick(); idle();
    chk("multi_rise_cnt", 32'(err_cnt), 1);
    chk("multi_rise_err", 32'(any_err), 1);
    sel_clr = 1'b1; data = 8'hFF;
    tick(); idle();
    for (int i = 0; i < 19; i++) begin
      evt = 8'h01;
      tick(); idle();
      if (i == 13) chk("cnt_reach_max", 32'(err_cnt), 15);
      sel_clr = 1'b1; data = 8'h01;
      tick(); idle();
    end
    chk("cnt_saturated", 32'(err_cnt), 15);
    evt = 8'h01; cnt_clr = 1'b1;
    tick(); idle();
    chk("cnt_clr_wins", 32'(err_cnt), 0);
    chk("cnt_clr_err",  32'(any_err), 1);

`ifdef APR_EVT_FIRST_ERR_EN
    do_reset();
    evt = 8'h30;
    tick();
    evt = 8'h01;
    tick(); idle();
    chk("first_idx_4",   32'(first_idx), 4);
    chk("first_valid_1", 32'(first_valid), 1);
    rd_sel = 2'd3; #1;
    chk("rd_first", 32'(rd_data), 'h0C);
    sel_clr = 1'b1; data = 8'h10;
    tick(); idle();
    chk("first_drop", 32'(first_valid), 0);
    evt = 8'h02;
    tick(); idle();
    chk("first_idx_1",   32'(first_idx), 1);
    chk("first_rearmed", 32'(first_valid), 1);
`else
    chk("nofirst_valid", 32'(first_valid), 0);
    chk("nofirst_idx",   32'(first_idx), 0);
    rd_sel = 2'd3; #1;
    chk("nofirst_rd", 32'(rd_data), 0);
`endif

    // Reset mid-operation
    sel_set = 1'b1; sel_en = 1'b1; data = 8'hFF; pia_ld = 1'b1; pia_in = 3'd5;
    tick(); idle();
    chk("pre_rst_flags", 32'(flags), 'hFF);
    chk("pre_rst_irq",   32'(irq), 1);
    RESET = 1'b1; evt = 8'hFF;
    tick();
    RESET = 1'b0; evt = 8'h00;
    chk("mid_rst_flags",   32'(flags), 0);
    chk("mid_rst_int_en",  32'(int_en), 0);
    chk("mid_rst_irq",     32'(irq), 0);
    chk("mid_rst_irq_pia", 32'(irq_pia), 0);
    chk("mid_rst_any_err", 32'(any_err), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_fvalid",  32'(first_valid), 0);
    tick();
    chk("post_rst_flags", 32'(flags), 0);
    chk("post_rst_err",   32'(any_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
